// File: rtl/cc_pkg.sv
// cc_pkg -- shared constants and types for the cache-controller read-data path.
// Widths of a cache line, an AXI R beat and the critical-word offset, the
// OKAY response code, and the canonical line-entry layout {data, offset, id}.
package cc_pkg;

    localparam int LINE_W   = 512;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 8;
    localparam int OFFSET_W = 3;
    localparam int ID_W_DEF = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Line-entry layout at the default AXI ID width. Modules with a different
    // ID width build the same layout locally and hand it to the FIFO as a type.
    typedef struct packed {
        logic [LINE_W-1:0]   data;
        logic [OFFSET_W-1:0] offset;
        logic [ID_W_DEF-1:0] id;
    } line_entry_t;

endpackage

// File: rtl/cc_line_fifo.sv
// cc_line_fifo -- DEPTH-entry synchronous FIFO of line entries.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (control state only)
//   push_i         write din_i at tail (ignored when full)
//   pop_i          advance head (ignored when empty)
//   din_i, dout_o  entry in / head entry out (dout_o valid while !empty_o)
//   full_o, empty_o, count_o   occupancy, all from registered state
module cc_line_fifo
    import cc_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = line_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   din_i,
    output entry_t                   dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Line storage is deliberately left out of reset; occupancy gates its use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/cc_serializer.sv
// cc_serializer -- streams buffered 512-bit cache lines as 8-beat 64-bit AXI R
// bursts, critical word first with 3-bit wrap.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   line_valid_i / line_ready_o      line handshake (ready = buffer not full)
//   line_data_i, line_offset_i, line_id_i   line payload, first word, AXI ID
//   inct_rvalid_o / inct_rready_i    R beat handshake
//   inct_rdata_o, inct_rid_o, inct_rresp_o, inct_rlast_o   R beat payload
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | buffer empty, rvalid low
// SEND  | head line being streamed, cnt = beat index 0..7
module cc_serializer
    import cc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_valid_i,
    output logic                line_ready_o,
    input  logic [LINE_W-1:0]   line_data_i,
    input  logic [OFFSET_W-1:0] line_offset_i,
    input  logic [ID_W-1:0]     line_id_i,
    output logic                inct_rvalid_o,
    input  logic                inct_rready_i,
    output logic [BEAT_W-1:0]   inct_rdata_o,
    output logic [ID_W-1:0]     inct_rid_o,
    output logic [1:0]          inct_rresp_o,
    output logic                inct_rlast_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef struct packed {
        logic [LINE_W-1:0]   data;
        logic [OFFSET_W-1:0] offset;
        logic [ID_W-1:0]     id;
    } entry_t;

    entry_t              wr_entry;
    entry_t              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [OFFSET_W-1:0] cnt;
    logic [OFFSET_W-1:0] word_sel;
    logic                push;
    logic                beat_hs;
    logic                last_hs;

    assign line_ready_o = ~fifo_full;
    assign push         = line_valid_i & line_ready_o;
    assign beat_hs      = inct_rvalid_o & inct_rready_i;
    assign last_hs      = beat_hs & (cnt == 3'd7);

    assign wr_entry.data   = line_data_i;
    assign wr_entry.offset = line_offset_i;
    assign wr_entry.id     = line_id_i;

    cc_line_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (last_hs),
        .din_i   (wr_entry),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (push) state_nxt = ST_SEND;
            ST_SEND: if (last_hs && (fifo_count == CW'(1)) && !push) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cnt wraps 7 -> 0 on the last beat, which is exactly where the next head starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (beat_hs) cnt <= cnt + 1'b1;
        end
    end

    // Offset + beat index, 3-bit wrap with no carry into the line address.
    assign word_sel = head.offset + cnt;

    // Payload is forced to zero while idle so stale, unreset line storage never shows.
    assign inct_rvalid_o = (state == ST_SEND) & ~fifo_empty;
    assign inct_rdata_o  = inct_rvalid_o ? head.data[word_sel*BEAT_W +: BEAT_W] : '0;
    assign inct_rid_o    = inct_rvalid_o ? head.id : '0;
    assign inct_rlast_o  = inct_rvalid_o & (cnt == 3'd7);
    assign inct_rresp_o  = RESP_OKAY;

endmodule

// File: tb/tb_cc_serializer.sv
module tb_cc_serializer;

    localparam int DEPTH = 2;
    localparam int ID_W  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_valid_i;
    logic          line_ready_o;
    logic [511:0]  line_data_i;
    logic [2:0]    line_offset_i;
    logic [ID_W-1:0] line_id_i;
    logic          inct_rvalid_o;
    logic          inct_rready_i;
    logic [63:0]   inct_rdata_o;
    logic [ID_W-1:0] inct_rid_o;
    logic [1:0]    inct_rresp_o;
    logic          inct_rlast_o;

    always #5 clk = ~clk;

    cc_serializer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_valid_i  (line_valid_i),
        .line_ready_o  (line_ready_o),
        .line_data_i   (line_data_i),
        .line_offset_i (line_offset_i),
        .line_id_i     (line_id_i),
        .inct_rvalid_o (inct_rvalid_o),
        .inct_rready_i (inct_rready_i),
        .inct_rdata_o  (inct_rdata_o),
        .inct_rid_o    (inct_rid_o),
        .inct_rresp_o  (inct_rresp_o),
        .inct_rlast_o  (inct_rlast_o)
    );

    // Reference model: list of buffered lines plus the beat index of the head line.
    typedef struct {
        logic [511:0]    data;
        int              off;
        logic [ID_W-1:0] id;
    } line_t;

    line_t mq[$];
    int    beat_k;
    int    tests;
    int    fails;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] word_of(input logic [511:0] d, input int w);
        return d[64*w +: 64];
    endfunction

    // Called at a negedge with inputs already driven: check, cross the edge, update model.
    task automatic tick(input string tag);
        int    w;
        bit    push_ok;
        line_t nl;
        #1;
        chk({tag, ".rvalid"}, 64'(inct_rvalid_o), 64'(mq.size() > 0));
        chk({tag, ".ready"},  64'(line_ready_o),  64'(mq.size() < DEPTH));
        chk({tag, ".rresp"},  64'(inct_rresp_o),  64'd0);
        if (mq.size() > 0) begin
            w = (mq[0].off + beat_k) % 8;
            chk({tag, ".rdata"}, inct_rdata_o, word_of(mq[0].data, w));
            chk({tag, ".rid"},   64'(inct_rid_o), 64'(mq[0].id));
            chk({tag, ".rlast"}, 64'(inct_rlast_o), 64'(beat_k == 7));
        end else begin
            chk({tag, ".rdata_idle"}, inct_rdata_o, 64'd0);
            chk({tag, ".rlast_idle"}, 64'(inct_rlast_o), 64'd0);
        end
        @(posedge clk);
        push_ok = line_valid_i && (mq.size() < DEPTH);
        if (mq.size() > 0 && inct_rready_i) begin
            beat_k++;
            if (beat_k == 8) begin
                void'(mq.pop_front());
                beat_k = 0;
            end
        end
        if (push_ok) begin
            nl.data = line_data_i;
            nl.off  = int'(line_offset_i);
            nl.id   = line_id_i;
            mq.push_back(nl);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [511:0] d, input logic [2:0] off,
                         input logic [ID_W-1:0] id, input logic rr);
        line_valid_i  = v;
        line_data_i   = d;
        line_offset_i = off;
        line_id_i     = id;
        inct_rready_i = rr;
    endtask

    task automatic idle_rr(input logic rr);
        drive(1'b0, '0, 3'd0, '0, rr);
    endtask

    logic [511:0] seq_line;
    int           guard;

    initial begin
        tests = 0;
        fails = 0;
        beat_k = 0;
        rst_n = 1'b0;
        idle_rr(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst.rvalid", 64'(inct_rvalid_o), 64'd0);
        chk("rst.rdata",  inct_rdata_o, 64'd0);
        chk("rst.rid",    64'(inct_rid_o), 64'd0);
        chk("rst.rlast",  64'(inct_rlast_o), 64'd0);
        chk("rst.rresp",  64'(inct_rresp_o), 64'd0);
        chk("rst.ready",  64'(line_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single line, offset 0, word w = A0+w.
        for (int w = 0; w < 8; w++) seq_line[64*w +: 64] = 64'hA0 + 64'(w);
        drive(1'b1, seq_line, 3'd0, 4'd5, 1'b1);
        tick("single_push");
        idle_rr(1'b1);
        for (int i = 0; i < 10; i++) tick("single");

        // Offset 6 critical-word-first wrap.
        drive(1'b1, seq_line, 3'd6, 4'd2, 1'b1);
        tick("off6_push");
        idle_rr(1'b1);
        for (int i = 0; i < 10; i++) tick("off6");

        // Back-to-back ids 3 and 9, third push held until space frees.
        drive(1'b1, rand_line(), 3'd1, 4'd3, 1'b1);
        tick("b2b_a");
        drive(1'b1, rand_line(), 3'd4, 4'd9, 1'b1);
        tick("b2b_b");
        drive(1'b1, rand_line(), 3'd7, 4'd12, 1'b1);
        guard = 0;
        while (mq.size() < 3 && guard < 20) begin
            tick("b2b_held");
            guard++;
            if (mq.size() == DEPTH + 0 && mq[mq.size()-1].id == 4'd12) break;
        end
        chk("b2b.third_accepted", 64'(mq[mq.size()-1].id), 64'd12);
        idle_rr(1'b1);
        for (int i = 0; i < 26; i++) tick("b2b_drain");

        // Stall for 5 cycles on beat 7.
        drive(1'b1, rand_line(), 3'd3, 4'd7, 1'b1);
        tick("stall_push");
        idle_rr(1'b1);
        guard = 0;
        while (beat_k != 7 && guard < 20) begin tick("stall_pre"); guard++; end
        chk("stall.reached_beat7", 64'(beat_k), 64'd7);
        idle_rr(1'b0);
        for (int i = 0; i < 5; i++) tick("stall_hold");
        idle_rr(1'b1);
        for (int i = 0; i < 3; i++) tick("stall_post");

        // Push on the final-beat pop edge with count = DEPTH-1.
        drive(1'b1, rand_line(), 3'd5, 4'd1, 1'b1);
        tick("edge_push_a");
        idle_rr(1'b1);
        guard = 0;
        while (beat_k != 7 && guard < 20) begin tick("edge_pre"); guard++; end
        drive(1'b1, rand_line(), 3'd2, 4'd14, 1'b1);
        tick("edge_push_b");
        chk("edge.count_unchanged", 64'(mq.size()), 64'd1);
        idle_rr(1'b1);
        for (int i = 0; i < 10; i++) tick("edge_drain");

        // Reset at beat 4 with another line queued.
        drive(1'b1, rand_line(), 3'd0, 4'd6, 1'b1);
        tick("rstmid_a");
        drive(1'b1, rand_line(), 3'd0, 4'd8, 1'b1);
        tick("rstmid_b");
        idle_rr(1'b1);
        guard = 0;
        while (beat_k != 4 && guard < 20) begin tick("rstmid_pre"); guard++; end
        rst_n = 1'b0;
        #1;
        chk("rstmid.rvalid", 64'(inct_rvalid_o), 64'd0);
        chk("rstmid.rlast",  64'(inct_rlast_o), 64'd0);
        chk("rstmid.ready",  64'(line_ready_o), 64'd1);
        mq.delete();
        beat_k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, rand_line(), 3'd4, 4'd11, 1'b1);
        tick("post_rst_push");
        idle_rr(1'b1);
        for (int i = 0; i < 10; i++) tick("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 2) == 0), rand_line(), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
            tick("rand");
        end
        idle_rr(1'b1);
        for (int i = 0; i < 20; i++) tick("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cc_serializer.md
# cc_serializer

Read-data serializer for the cache controller. Accepts whole 512-bit cache lines (from the hit path or a completed fill), buffers up to DEPTH lines, and streams each as an 8-beat, 64-bit AXI R burst toward the interconnect, critical-word-first with wrap-around. It is the transmit-side counterpart of the data fill unit's R-channel deserializer.

## Interface
- DEPTH, 2, line buffer entries (power of two, ≥2)
- ID_W, 4, AXI ID width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- line_valid_i  in  1  line request valid
- line_ready_o  out  1  buffer can accept a line
- line_data_i  in  512  line data; word w = bits [64w+63:64w]
- line_offset_i  in  3  first word to send (addr[5:3])
- line_id_i  in  ID_W  AXI ID of the originating request
- inct_rvalid_o  out  1  R beat valid
- inct_rready_i  in  1  R beat accepted
- inct_rdata_o  out  64  beat data
- inct_rid_o  out  ID_W  beat ID
- inct_rresp_o  out  2  always 2'b00 (OKAY)
- inct_rlast_o  out  1  final beat of burst

## Operation
- Line accepted when line_valid_i & line_ready_o on a rising edge; {data, offset, id} written at tail.
- Burst always serves the head entry; beat counter cnt (3 bits) starts at 0.
- Beat k sends word (offset + k) mod 8 — 3-bit wrap, no carry (offset 6: words 6,7,0,1,2,3,4,5).
- inct_rid_o = head id for every beat; inct_rlast_o = (cnt == 7) & inct_rvalid_o.
- Handshake inct_rvalid_o & inct_rready_i: cnt increments; at cnt==7, cnt→0 and head popped.
- AXI rule: once inct_rvalid_o is high, rdata/rid/rlast stay stable and rvalid stays high until accepted; rvalid never depends on rready.
- Single FSM, states IDLE (buffer empty) / SEND (buffer non-empty). IDLE→SEND on first push; SEND→IDLE on last-beat handshake with no other entry and no same-cycle push; otherwise stays SEND with next head.
- Buffer state: wr_ptr, rd_ptr (log2 DEPTH bits, wrapping), count (log2 DEPTH+1 bits).

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by system): pointers, count, cnt cleared; inct_rvalid_o=0, inct_rlast_o=0, inct_rdata_o=0, inct_rid_o=0, inct_rresp_o=0, line_ready_o=1.
- Reset mid-burst: all buffered lines and partial burst discarded; rvalid drops immediately.
- Latency: line accepted at edge N into empty buffer → first beat valid cycle N+1 (after that edge).
- Full rate: with rready held high, 8 beats in 8 consecutive cycles; next buffered line's beat 0 follows the last beat with no bubble.
- line_ready_o = (count < DEPTH), from registered state only. Full: push refused even if a pop occurs the same cycle.
- Push and pop same cycle (count < DEPTH): both take effect, count unchanged.
- Push into empty while nothing pending: no bypass; data appears next cycle.
- rready low stalls indefinitely; outputs held; cnt frozen.
- Outputs are driven from registered buffer/counter state through the word mux; no input-to-output combinational path.

## Structure
- Shared package cc_pkg: LINE_W=512, BEAT_W=64, BEATS=8, OFFSET_W=3, RESP_OKAY=2'b00, line-entry struct {data, offset, id}.
- One sub-module: cc_line_fifo (DEPTH-entry synchronous FIFO of line-entry struct, full/empty/count, async reset of control state only; data array not reset).
- Top holds FSM, beat counter, word-select mux.

## Test plan
- Single line, offset 0, data word w = 64'hA0+w, rready=1 → 8 beats 0xA0..0xA7 in consecutive cycles, rlast only on 8th, rid=line_id, rvalid low afterwards.
- Offset 6 → words 6,7,0,1,2,3,4,5; rlast on word 5.
- Two lines pushed back-to-back (ids 3, 9), rready=1 → 16 contiguous beats, ID switches 3→9 with no idle cycle; third push while both held is refused (line_ready_o=0) until last beat of id 3.
- rready toggled randomly with rready=0 for 5 cycles on beat 7 → rvalid, rdata, rlast stable throughout stall; no beat lost or duplicated.
- Push on the same edge as the final-beat pop with count=DEPTH-1 → accepted, count unchanged, next burst starts next cycle.
- rst_n asserted at beat 4 of a burst with one more line queued → rvalid=0 immediately, line_ready_o=1 after release; new line afterwards starts at its own beat 0.
